// File: rtl/dm_responder_pkg.sv
// Shared load/store size encodings and responder FSM states.
// The control path uses the same constants.
package dm_responder_pkg;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;
    localparam logic [1:0] LS_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the memory stage (master) and the data memory (slave).
interface dm_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  LS_op;
    logic        sign;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, LS_op, sign,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, LS_op, sign,
        output ack, rdata, err
    );

endinterface

// File: rtl/dm_lane.sv
// Byte-lane steering: merges store data into the old word and extracts/extends load data.
module dm_lane
    import dm_responder_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  ls_op_i,
    input  logic        sign_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_word_o,
    output logic        misaligned_o
);

    logic [4:0]  shamt;
    logic [31:0] byte_mask;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shamt     = {offset_i, 3'b000};
        byte_mask = 32'h0000_00ff << shamt;
        byte_val  = 8'(old_word_i >> shamt);
        half_val  = offset_i[1] ? old_word_i[31:16] : old_word_i[15:0];

        store_word_o = old_word_i;
        load_word_o  = '0;
        misaligned_o = 1'b0;

        case (ls_op_i)
            LS_WORD: begin
                misaligned_o = (offset_i != 2'b00);
                store_word_o = wdata_i;
                load_word_o  = old_word_i;
            end
            LS_HALF: begin
                misaligned_o = offset_i[0];
                store_word_o = offset_i[1] ? {wdata_i[15:0], old_word_i[15:0]}
                                           : {old_word_i[31:16], wdata_i[15:0]};
                load_word_o  = {{16{sign_i & half_val[15]}}, half_val};
            end
            LS_BYTE: begin
                store_word_o = (old_word_i & ~byte_mask) | ({24'h0, wdata_i[7:0]} << shamt);
                load_word_o  = {{24{sign_i & byte_val[7]}}, byte_val};
            end
            default: begin
                store_word_o = old_word_i;
                load_word_o  = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time over req/ack, with fixed wait states.
// The array access happens on the edge that enters RESP; the response is registered.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);

    localparam int unsigned IdxW     = ADDR_WIDTH - 2;
    localparam int unsigned Depth    = 1 << IdxW;
    localparam logic [3:0]  WaitInit = WAIT_CYCLES[3:0];

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [1:0]              ls_op_q, ls_op_d;
    logic                    sign_q, sign_d;
    logic                    ack_q, ack_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [31:0]             mem_q [Depth];

    logic                    commit;
    logic                    in_idle;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_we;
    logic [31:0]             cur_wdata;
    logic [1:0]              cur_ls_op;
    logic                    cur_sign;
    logic [IdxW-1:0]         cur_idx;
    logic [31:0]             store_word;
    logic [31:0]             load_word;
    logic                    misaligned;
    logic                    err_now;
    logic                    mem_we;

    // With no wait states the commit happens in IDLE, before the latches hold the request.
    assign in_idle   = (state_q == IDLE);
    assign cur_addr  = in_idle ? bus.addr[ADDR_WIDTH-1:0] : addr_q;
    assign cur_we    = in_idle ? bus.we    : we_q;
    assign cur_wdata = in_idle ? bus.wdata : wdata_q;
    assign cur_ls_op = in_idle ? bus.LS_op : ls_op_q;
    assign cur_sign  = in_idle ? bus.sign  : sign_q;
    assign cur_idx   = cur_addr[ADDR_WIDTH-1:2];

    dm_lane u_lane (
        .old_word_i   (mem_q[cur_idx]),
        .wdata_i      (cur_wdata),
        .offset_i     (cur_addr[1:0]),
        .ls_op_i      (cur_ls_op),
        .sign_i       (cur_sign),
        .store_word_o (store_word),
        .load_word_o  (load_word),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ls_op_d = ls_op_q;
        sign_d  = sign_q;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr[ADDR_WIDTH-1:0];
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    ls_op_d = bus.LS_op;
                    sign_d  = bus.sign;
                    cnt_d   = WaitInit;
                    if (WaitInit != 4'd0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_now = misaligned | (cur_ls_op == LS_RSVD);
        mem_we  = commit & cur_we & ~err_now;
        ack_d   = commit;
        err_d   = commit & err_now;
        rdata_d = (commit && !err_now && !cur_we) ? load_word : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ls_op_q <= LS_WORD;
            sign_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ls_op_q <= ls_op_d;
            sign_q  <= sign_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (mem_we) begin
                mem_q[cur_idx] <= store_word;
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a zero-wait and a three-wait instance run directed vectors.
module tb_dm_responder;
    import dm_responder_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  rst_v;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [1:0]  op_v    [2];
    logic [1:0]  sign_v;
    logic [1:0]  ack_v;
    logic [31:0] rdata_v [2];
    logic [1:0]  err_v;

    exp_t exp0 [$];
    exp_t exp1 [$];

    dm_responder_if bus0 ();
    dm_responder_if bus1 ();

    assign bus0.req   = req_v[0];
    assign bus0.we    = we_v[0];
    assign bus0.addr  = addr_v[0];
    assign bus0.wdata = wdata_v[0];
    assign bus0.LS_op = op_v[0];
    assign bus0.sign  = sign_v[0];
    assign bus1.req   = req_v[1];
    assign bus1.we    = we_v[1];
    assign bus1.addr  = addr_v[1];
    assign bus1.wdata = wdata_v[1];
    assign bus1.LS_op = op_v[1];
    assign bus1.sign  = sign_v[1];
    assign ack_v      = {bus1.ack, bus0.ack};
    assign err_v      = {bus1.err, bus0.err};
    assign rdata_v[0] = bus0.rdata;
    assign rdata_v[1] = bus1.rdata;

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (rst_v[0]),
        .bus   (bus0.slave)
    );

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut1 (
        .clk   (clk),
        .reset (rst_v[1]),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input int s, input exp_t e);
        checks++;
        if (rdata_v[s] !== e.rdata || err_v[s] !== e.err || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s (dut%0d): got rdata=%h err=%b cycle=%0d, want rdata=%h err=%b cycle=%0d",
                     e.name, s, rdata_v[s], err_v[s], cyc, e.rdata, e.err, e.cyc);
        end
    endtask

    task automatic check_quiet(input int s, input string name);
        checks++;
        if (ack_v[s] !== 1'b0 || rdata_v[s] !== 32'h0 || err_v[s] !== 1'b0) begin
            errors++;
            $display("FAIL %s (dut%0d): got ack=%b rdata=%h err=%b, want all zero",
                     name, s, ack_v[s], rdata_v[s], err_v[s]);
        end
    endtask

    // Monitors: every ack pops one expectation; outside ack the outputs must be zero.
    always @(negedge clk) begin
        if (!rst_v[0]) begin
            if (ack_v[0]) begin
                if (exp0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack (dut0): got ack=1 rdata=%h, want no ack", rdata_v[0]);
                end else compare(0, exp0.pop_front());
            end else check_quiet(0, "idle_outputs");
        end
    end

    always @(negedge clk) begin
        if (!rst_v[1]) begin
            if (ack_v[1]) begin
                if (exp1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack (dut1): got ack=1 rdata=%h, want no ack", rdata_v[1]);
                end else compare(1, exp1.pop_front());
            end else check_quiet(1, "idle_outputs");
        end
    end

    // Presents one request and holds it until ack; req stays high afterwards.
    task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] op, input logic sg, input logic [31:0] er,
                       input logic ee, input string name);
        exp_t e;
        bit   got;
        @(negedge clk);
        we_v[s]    = w;
        addr_v[s]  = a;
        wdata_v[s] = wd;
        op_v[s]    = op;
        sign_v[s]  = sg;
        req_v[s]   = 1'b1;
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + ((s == 0) ? 1 : 4);
        e.name  = name;
        if (s == 0) exp0.push_back(e);
        else        exp1.push_back(e);
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (ack_v[s]) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout (dut%0d): got no ack, want ack", name, s);
        end
    endtask

    task automatic release_req(input int s);
        @(negedge clk);
        req_v[s] = 1'b0;
    endtask

    initial begin
        rst_v  = 2'b11;
        req_v  = 2'b00;
        we_v   = 2'b00;
        sign_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
            op_v[i]    = LS_WORD;
        end
        repeat (3) @(negedge clk);
        rst_v = 2'b00;
        @(negedge clk);
        check_quiet(0, "reset_state");
        check_quiet(1, "reset_state");

        // Zero wait states: word, byte and half accesses, alignment and address wrap.
        txn(0, 1, 32'h10, 32'h1234_5678, LS_WORD, 0, 32'h0, 0, "st_word_10");
        txn(0, 0, 32'h10, 32'h0, LS_WORD, 0, 32'h1234_5678, 0, "ld_word_10");
        txn(0, 1, 32'h13, 32'h0000_00ab, LS_BYTE, 0, 32'h0, 0, "st_byte_13");
        txn(0, 0, 32'h10, 32'h0, LS_WORD, 1, 32'hab34_5678, 0, "ld_word_merged");
        txn(0, 0, 32'h13, 32'h0, LS_BYTE, 1, 32'hffff_ffab, 0, "ld_byte_sext");
        txn(0, 0, 32'h13, 32'h0, LS_BYTE, 0, 32'h0000_00ab, 0, "ld_byte_zext");
        txn(0, 0, 32'h10, 32'h0, LS_BYTE, 1, 32'h0000_0078, 0, "ld_byte_pos");
        txn(0, 1, 32'h22, 32'hcafe_8001, LS_HALF, 0, 32'h0, 0, "st_half_22");
        txn(0, 0, 32'h22, 32'h0, LS_HALF, 1, 32'hffff_8001, 0, "ld_half_sext");
        txn(0, 0, 32'h22, 32'h0, LS_HALF, 0, 32'h0000_8001, 0, "ld_half_zext");
        txn(0, 0, 32'h21, 32'h0, LS_HALF, 1, 32'h0, 1, "ld_half_misaligned");
        txn(0, 1, 32'h21, 32'hffff_ffff, LS_HALF, 0, 32'h0, 1, "st_half_misaligned");
        txn(0, 0, 32'h20, 32'h0, LS_WORD, 0, 32'h8001_0000, 0, "ld_word_20_unchanged");
        txn(0, 1, 32'h1004, 32'h55aa_55aa, LS_WORD, 0, 32'h0, 0, "st_word_wrap");
        txn(0, 0, 32'h004, 32'h0, LS_WORD, 0, 32'h55aa_55aa, 0, "ld_word_wrap");
        txn(0, 0, 32'h004, 32'h0, LS_RSVD, 0, 32'h0, 1, "ld_reserved");
        txn(0, 1, 32'h004, 32'h0, LS_RSVD, 0, 32'h0, 1, "st_reserved");
        txn(0, 0, 32'h006, 32'h0, LS_WORD, 0, 32'h0, 1, "ld_word_misaligned");
        txn(0, 0, 32'h004, 32'h0, LS_WORD, 0, 32'h55aa_55aa, 0, "ld_word_after_rsvd");
        release_req(0);

        // Three wait states: latency, held req ignored, back-to-back acceptance.
        txn(1, 1, 32'h10, 32'h1234_5678, LS_WORD, 0, 32'h0, 0, "w3_st_word");
        txn(1, 0, 32'h10, 32'h0, LS_WORD, 0, 32'h1234_5678, 0, "w3_ld_word");
        release_req(1);

        // Reset during WAIT of a store: no ack, nothing written, memory cleared.
        @(negedge clk);
        we_v[1] = 1'b1; addr_v[1] = 32'h40; wdata_v[1] = 32'hdead_beef;
        op_v[1] = LS_WORD; sign_v[1] = 1'b0; req_v[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_v[1] = 1'b1;
        req_v[1] = 1'b0;
        @(negedge clk);
        rst_v[1] = 1'b0;
        check_quiet(1, "post_reset_outputs");
        repeat (4) @(negedge clk);
        txn(1, 0, 32'h40, 32'h0, LS_WORD, 0, 32'h0, 0, "w3_ld_aborted_store");
        txn(1, 0, 32'h10, 32'h0, LS_WORD, 0, 32'h0, 0, "w3_ld_cleared_by_reset");
        release_req(1);

        for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) @(negedge clk);
        if (exp0.size() != 0 || exp1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", exp0.size(), exp1.size());
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the far end of the CPU datapath's load/store interface (mem_write, LS_op, sign).
- Accepts one load or store request at a time through a req/ack handshake and inserts a configurable number of wait states.
- Performs word, halfword and byte stores with lane merging, and returns loads zero-extended or sign-extended.
- Holds the data memory array itself; it is the block the pipelined CPU's memory stage talks to.

Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded (array depth = 2^(ADDR_WIDTH-2) words).
- WAIT_CYCLES, 0, wait states between request acceptance and ack (0..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- LS_op  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
- sign  input  1  load extension: 1 sign-extend, 0 zero-extend.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  load result, valid while ack=1.
- err  output  1  misaligned or reserved access, valid while ack=1.

Behaviour:
- Reset (synchronous, active-high; clk and reset named as in the rest of the design):
  - state = IDLE; ack = 0, rdata = 0, err = 0; wait counter = 0; every memory word = 0.
  - Reset mid-transaction aborts it. A store not yet committed is never written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - When req=1, latch addr, we, wdata, LS_op and sign; load counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - When req=0, stay in IDLE.
- WAIT: decrement the counter; when it reaches 1, go to RESP.
- Commit point: the store write and load read happen at the edge entering RESP.
- RESP:
  - ack=1 for exactly one cycle; rdata and err are registered values.
  - Always return to IDLE.
- Latency and throughput:
  - ack is high in cycle N+WAIT_CYCLES+1, where N is the cycle req was sampled.
  - Maximum throughput is one transaction per WAIT_CYCLES+2 cycles.
- req during WAIT/RESP is ignored. The requester must hold req and its fields until it sees ack; req still high in the IDLE cycle after ack starts a new transaction.
- ack, rdata and err are 0 in every cycle outside RESP.
- Alignment:
  - Word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
  - A misaligned access or LS_op=11 gives err=1 and rdata=0, and no memory change.
- Addressing:
  - Word index = addr[ADDR_WIDTH-1:2]; upper address bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH.
  - Little-endian lanes: byte k of a word is bits [8k+7:8k], with k = addr[1:0].
  - A halfword at addr[1]=1 occupies bits [31:16].
- Stores:
  - Only the selected lanes change (read-modify-write of one word).
  - Byte store writes wdata[7:0]; half store writes wdata[15:0].
- Loads:
  - The selected lane is right-aligned.
  - Bits above the lane are all ones if sign=1 and the lane MSB=1; otherwise they are zero.
  - Word loads ignore sign.

Decomposition:
- Shared package:
  - LS_op encodings: LS_WORD=2'b00, LS_HALF=2'b01, LS_BYTE=2'b10, LS_RSVD=2'b11.
  - State encodings IDLE/WAIT/RESP.
  - These constants are shared with CTRL.
- One combinational sub-module, dm_lane: takes the old word, wdata, addr[1:0], LS_op and sign. It produces the merged store word, the extended load value and the misaligned flag.
- dm_responder holds the FSM, the counter, the latches and the array.

Test Plan:
1. WAIT_CYCLES=0: store word 0x12345678 @0x10, then load word @0x10 -> ack 1 cycle after each req; rdata=0x12345678, err=0.
2. Store byte 0xAB @0x13 over word 0x12345678 @0x10 -> word reads 0xAB345678. Byte load @0x13 with sign=1 gives 0xFFFFFFAB; with sign=0 gives 0x000000AB.
3. Half store 0x8001 @0x22, half load @0x22 with sign=1 -> rdata=0xFFFF8001. Half load @0x21 -> err=1, rdata=0, memory unchanged.
4. WAIT_CYCLES=3: req sampled in cycle 5 -> ack only in cycle 9. req held high through cycles 6-9 starts no extra transaction; a new one is accepted in cycle 10.
5. reset asserted in the WAIT state of a store of 0xDEADBEEF @0x40 -> ack never pulses; afterwards the load @0x40 returns 0. All outputs are 0 the cycle after reset.
6. Store word 0x55AA55AA @0x1004 with ADDR_WIDTH=12, then load word @0x004 -> 0x55AA55AA (address wrap). LS_op=11 -> err=1.
